// File: rtl/data_mod_pkg.sv
// Shared types and helpers for the data_mod_gear word-to-symbol repacker.
package data_mod_pkg;

  // Word fetch sequence: request issued in IDLE, source drives data during REQ, word captured in CAP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAP  = 2'd2
  } fetch_state_t;

  // Bits needed to count 0..buf_w valid buffer bits.
  function automatic int cnt_width(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/data_mod_sym_map.sv
// Combinational symbol mapper: plain binary, or Gray code when DATA_MOD_GRAY_EN is defined.
module data_mod_sym_map #(
  parameter int SYM_W = 5
) (
  input  logic [SYM_W-1:0] sym,
  output logic [SYM_W-1:0] mapped
);

  // Map the raw symbol onto the line code.
  always_comb begin
`ifdef DATA_MOD_GRAY_EN
    mapped = sym ^ (sym >> 1);
`else
    mapped = sym;
`endif
  end

endmodule

// File: rtl/data_mod_gear.sv
// Word-to-symbol gearbox: fetches DIN_W-bit words over rdy/rd, repacks them
// through a bit buffer and emits SYM_W-bit symbols on dmod/mod_en with
// backpressure (mod_rdy) and a zero-padding flush.
// Optional feature macro: DATA_MOD_GRAY_EN (Gray-coded dmod).
module data_mod_gear
  import data_mod_pkg::*;
#(
  parameter int DIN_W     = 8,
  parameter int SYM_W     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rdy,
  input  logic [DIN_W-1:0] data_in,
  output logic             rd,
  input  logic             mod_rdy,
  input  logic             flush,
  output logic             mod_en,
  output logic [SYM_W-1:0] dmod,
  output logic             busy
);

  localparam int BUF_W = DIN_W + SYM_W - 1;
  localparam int CNT_W = cnt_width(BUF_W);
  localparam logic [CNT_W-1:0] SYM_CNT = CNT_W'(SYM_W);
  localparam logic [CNT_W-1:0] DIN_CNT = CNT_W'(DIN_W);

  fetch_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BUF_W-1:0] bit_buf, bit_buf_nxt;
  logic             flush_pend, flush_pend_nxt;
  logic             rd_nxt, mod_en_nxt, busy_nxt;
  logic [SYM_W-1:0] dmod_nxt, oldest_sym, mapped_sym;
  logic [BUF_W-1:0] word_ext, word_aligned, buf_shifted;

  // Bit ordering: where the oldest symbol sits and where a new word lands behind the valid bits.
  always_comb begin
    word_ext = BUF_W'(data_in);
    if (MSB_FIRST) begin
      oldest_sym   = bit_buf[BUF_W-1 -: SYM_W];
      buf_shifted  = bit_buf << SYM_W;
      word_aligned = (word_ext << (BUF_W - DIN_W)) >> cnt;
    end else begin
      oldest_sym   = bit_buf[SYM_W-1:0];
      buf_shifted  = bit_buf >> SYM_W;
      word_aligned = word_ext << cnt;
    end
  end

  data_mod_sym_map #(
    .SYM_W(SYM_W)
  ) u_sym_map (
    .sym   (oldest_sym),
    .mapped(mapped_sym)
  );

  // Next-state logic: emission, flush drain and the fetch FSM.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_buf_nxt    = bit_buf;
    flush_pend_nxt = flush_pend | flush;
    rd_nxt         = 1'b0;
    mod_en_nxt     = 1'b0;
    dmod_nxt       = dmod;

    // Unused buffer bits are always zero, so the residual symbol comes out already zero-padded.
    if ((cnt >= SYM_CNT) && mod_rdy) begin
      mod_en_nxt  = 1'b1;
      dmod_nxt    = mapped_sym;
      cnt_nxt     = cnt - SYM_CNT;
      bit_buf_nxt = buf_shifted;
    end else if (flush_pend && (state == IDLE) && (cnt < SYM_CNT)) begin
      if (cnt == {CNT_W{1'b0}}) begin
        flush_pend_nxt = 1'b0;
      end else if (mod_rdy) begin
        mod_en_nxt     = 1'b1;
        dmod_nxt       = mapped_sym;
        cnt_nxt        = {CNT_W{1'b0}};
        bit_buf_nxt    = {BUF_W{1'b0}};
        flush_pend_nxt = 1'b0;
      end else begin
        flush_pend_nxt = 1'b1;
      end
    end else begin
      mod_en_nxt = 1'b0;
    end

    // Capture only happens with cnt<SYM_W, so it never collides with an emission above.
    case (state)
      IDLE: begin
        if (rdy && (cnt < SYM_CNT) && !flush_pend) begin
          state_nxt = REQ;
          rd_nxt    = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      REQ: begin
        state_nxt = CAP;
      end
      CAP: begin
        state_nxt   = IDLE;
        cnt_nxt     = cnt + DIN_CNT;
        bit_buf_nxt = bit_buf | word_aligned;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (cnt_nxt != {CNT_W{1'b0}}) || (state_nxt != IDLE) || flush_pend_nxt;
  end

  // State and output registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= {CNT_W{1'b0}};
      bit_buf    <= {BUF_W{1'b0}};
      flush_pend <= 1'b0;
      rd         <= 1'b0;
      mod_en     <= 1'b0;
      dmod       <= {SYM_W{1'b0}};
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_buf    <= bit_buf_nxt;
      flush_pend <= flush_pend_nxt;
      rd         <= rd_nxt;
      mod_en     <= mod_en_nxt;
      dmod       <= dmod_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_data_mod_gear.sv
// Self-checking bench for data_mod_gear: default 8->5 MSB-first instance (a)
// and an 8->8 LSB-first instance (b), scoreboard of expected symbols.
module tb_data_mod_gear;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       rdy_a, rd_a, mod_rdy_a, flush_a, mod_en_a, busy_a;
  logic [7:0] data_a;
  logic [4:0] dmod_a;
  logic       rdy_b, rd_b, mod_rdy_b, flush_b, mod_en_b, busy_b;
  logic [7:0] data_b;
  logic [7:0] dmod_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] word_q_a[$];
  logic [7:0] word_q_b[$];
  logic [4:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] held_a, held_b;
  bit         pend_a, pend_b;

  data_mod_gear u_dut_a (
    .clk(clk), .reset_n(reset_n), .rdy(rdy_a), .data_in(data_a), .rd(rd_a),
    .mod_rdy(mod_rdy_a), .flush(flush_a), .mod_en(mod_en_a), .dmod(dmod_a), .busy(busy_a)
  );

  data_mod_gear #(.DIN_W(8), .SYM_W(8), .MSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .rdy(rdy_b), .data_in(data_b), .rd(rd_b),
    .mod_rdy(mod_rdy_b), .flush(flush_b), .mod_en(mod_en_b), .dmod(dmod_b), .busy(busy_b)
  );

  function automatic logic [4:0] map5(input logic [4:0] s);
`ifdef DATA_MOD_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  function automatic logic [7:0] map8(input logic [7:0] s);
`ifdef DATA_MOD_GRAY_EN
    return s ^ (s >> 1);
`else
    return s;
`endif
  endfunction

  // One cycle at the falling edge: source model answers rd, data valid two edges after rd was set.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (pend_a) begin data_a = held_a; pend_a = 1'b0; end
    if (rd_a && word_q_a.size() != 0) begin
      held_a = word_q_a.pop_front(); pend_a = 1'b1; data_a = ~held_a;
    end
    rdy_a = (word_q_a.size() != 0);
    if (pend_b) begin data_b = held_b; pend_b = 1'b0; end
    if (rd_b && word_q_b.size() != 0) begin
      held_b = word_q_b.pop_front(); pend_b = 1'b1; data_b = ~held_b;
    end
    rdy_b = (word_q_b.size() != 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (rd_a !== 1'b0 || mod_en_a !== 1'b0 || dmod_a !== 5'h00 || busy_a !== 1'b0 ||
          rd_b !== 1'b0 || mod_en_b !== 1'b0 || dmod_b !== 8'h00 || busy_b !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: a rd=%b en=%b dmod=%h busy=%b b rd=%b en=%b dmod=%h busy=%b, required all 0",
                 rd_a, mod_en_a, dmod_a, busy_a, rd_b, mod_en_b, dmod_b, busy_b);
      end
    end
    rdy_a = 1'b0; rdy_b = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if (rd_a !== 1'b0 || busy_a !== 1'b0 || mod_en_a !== 1'b0) begin
        n_err++;
        $display("FAIL idle_no_rd: rd=%b busy=%b mod_en=%b, required 0 0 0", rd_a, busy_a, mod_en_a);
      end
    end
  endtask

  task automatic test_basic();
    int got = 0; int budget = 0; int t_rd = -1; int t_en = -1;
    logic [4:0] e;
    mod_rdy_a = 1'b1; flush_a = 1'b0;
    word_q_a.push_back(8'hA5); word_q_a.push_back(8'h3C);
    exp_a.push_back(map5(5'h14)); exp_a.push_back(map5(5'h14));
    exp_a.push_back(map5(5'h1E)); exp_a.push_back(map5(5'h00));
    while (exp_a.size() != 0 && budget < 80) begin
      tick(); budget++;
      flush_a = 1'b0;
      if (rd_a && t_rd < 0) t_rd = cyc;
      if (mod_en_a) begin
        if (t_en < 0) t_en = cyc;
        e = exp_a.pop_front(); got++;
        n_vec++;
        if (dmod_a !== e) begin
          n_err++;
          $display("FAIL basic_sym%0d: dmod=%h, required %h", got, dmod_a, e);
        end
        if (got == 3) flush_a = 1'b1;
      end
    end
    n_vec++;
    if (exp_a.size() != 0) begin
      n_err++;
      $display("FAIL basic_timeout: %0d symbols missing, required 0", exp_a.size());
      exp_a.delete();
    end
    n_vec++;
    if (t_en - t_rd != 3) begin
      n_err++;
      $display("FAIL basic_latency: rd-to-mod_en=%0d cycles, required 3", t_en - t_rd);
    end
    n_vec++;
    if (busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL basic_busy_end: busy=%b, required 0", busy_a);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (mod_en_a !== 1'b0 || busy_a !== 1'b0 || rd_a !== 1'b0) begin
        n_err++;
        $display("FAIL basic_quiet: mod_en=%b busy=%b rd=%b, required 0 0 0", mod_en_a, busy_a, rd_a);
      end
    end
  endtask

  task automatic test_backpressure();
    int rd_cnt = 0; int got = 0; int budget = 0;
    logic [4:0] e;
    mod_rdy_a = 1'b0; flush_a = 1'b0;
    word_q_a.push_back(8'hA5); word_q_a.push_back(8'h3C);
    exp_a.push_back(map5(5'h14)); exp_a.push_back(map5(5'h14));
    exp_a.push_back(map5(5'h1E)); exp_a.push_back(map5(5'h00));
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rd_a) rd_cnt++;
      n_vec++;
      if (mod_en_a !== 1'b0) begin
        n_err++;
        $display("FAIL bp_no_emit: mod_en=%b with mod_rdy=0, required 0", mod_en_a);
      end
    end
    n_vec++;
    if (rd_cnt != 1 || busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL bp_single_rd: rd pulses=%0d busy=%b, required 1 1", rd_cnt, busy_a);
    end
    mod_rdy_a = 1'b1;
    tick();
    e = exp_a.pop_front(); got++;
    n_vec++;
    if (mod_en_a !== 1'b1 || dmod_a !== e) begin
      n_err++;
      $display("FAIL bp_release: mod_en=%b dmod=%h, required 1 %h", mod_en_a, dmod_a, e);
    end
    tick();
    n_vec++;
    if (rd_a !== 1'b1) begin
      n_err++;
      $display("FAIL bp_rd_reissue: rd=%b, required 1", rd_a);
    end
    while (exp_a.size() != 0 && budget < 80) begin
      tick(); budget++;
      flush_a = 1'b0;
      if (mod_en_a) begin
        e = exp_a.pop_front(); got++;
        n_vec++;
        if (dmod_a !== e) begin
          n_err++;
          $display("FAIL bp_sym%0d: dmod=%h, required %h", got, dmod_a, e);
        end
        if (got == 3) flush_a = 1'b1;
      end
    end
    n_vec++;
    if (exp_a.size() != 0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: %0d symbols missing busy=%b, required 0 0", exp_a.size(), busy_a);
      exp_a.delete();
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    mod_rdy_a = 1'b1; flush_a = 1'b0;
    word_q_a.push_back(8'hA5);
    tick();
    while (!rd_a && budget < 10) begin
      tick(); budget++;
    end
    n_vec++;
    if (rd_a !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_rd: rd=%b before reset, required 1", rd_a);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (rd_a !== 1'b0 || busy_a !== 1'b0 || mod_en_a !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: rd=%b busy=%b mod_en=%b, required 0 0 0", rd_a, busy_a, mod_en_a);
    end
    pend_a = 1'b0; word_q_a.delete(); rdy_a = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (mod_en_a !== 1'b0 || busy_a !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_no_capture: mod_en=%b busy=%b, required 0 0", mod_en_a, busy_a);
      end
    end
  endtask

  task automatic test_gear8();
    int budget = 0; int got = 0;
    logic [7:0] w, e;
    mod_rdy_b = 1'b1; flush_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom_range(0, 255));
      word_q_b.push_back(w);
      exp_b.push_back(map8(w));
    end
    while (exp_b.size() != 0 && budget < 100) begin
      tick(); budget++;
      if (mod_en_b) begin
        e = exp_b.pop_front(); got++;
        n_vec++;
        if (dmod_b !== e) begin
          n_err++;
          $display("FAIL gear8_sym%0d: dmod=%h, required %h", got, dmod_b, e);
        end
      end
    end
    n_vec++;
    if (exp_b.size() != 0) begin
      n_err++;
      $display("FAIL gear8_timeout: %0d symbols missing, required 0", exp_b.size());
      exp_b.delete();
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (mod_en_b !== 1'b0 || busy_b !== 1'b0) begin
        n_err++;
        $display("FAIL gear8_quiet: mod_en=%b busy=%b, required 0 0", mod_en_b, busy_b);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    rdy_a = 1'b0; mod_rdy_a = 1'b1; flush_a = 1'b0; data_a = 8'h00;
    rdy_b = 1'b0; mod_rdy_b = 1'b1; flush_b = 1'b0; data_b = 8'h00;
    held_a = 8'h00; held_b = 8'h00; pend_a = 1'b0; pend_b = 1'b0;
    test_reset();
    test_idle();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_gear8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
